// File: rtl/nes_pad_responder_pkg.sv
// nes_pkg: shared constants for the NES pad responder.
// Button bit indices, frame width and FSM state encoding.
package nes_pkg;

  localparam int NES_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } nes_state_e;

endpackage

// File: rtl/nes_pad_responder_debounce.sv
// nes_debounce: one-bit stable-count filter, built only with NES_DEBOUNCE_EN.
// Ports: clk, reset (async active-low), din (synchronized), dout (filtered).
`ifdef NES_DEBOUNCE_EN
module nes_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // dout follows din only after CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: NES controller (responder side); host drives latch/nes_clk.
// Ports: clk, reset(n), latch, nes_clk, buttons[8] -> data, frame_done, link_active, snapshot. Option: NES_DEBOUNCE_EN.
module nes_pad_responder
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int FRAME_TIMEOUT   = 5000000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                latch,
  input  logic                nes_clk,
  input  logic [NES_BITS-1:0] buttons,
  output logic                data,
  output logic                frame_done,
  output logic                link_active,
  output logic [NES_BITS-1:0] snapshot
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("nes_pad_responder: illegal parameter set");
  end

  // {latch, nes_clk, buttons} move through the sync chain together
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    logic [NES_BITS+1:0] d;
    logic [NES_BITS+1:0] q;
    if (i == 0) begin : g_first
      assign d = {latch, nes_clk, buttons};
    end else begin : g_next
      assign d = g_sync[i-1].q;
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= d;
    end
  end

  logic [NES_BITS+1:0] sync_w;
  logic                latch_s;
  logic                nclk_s;
  logic [NES_BITS-1:0] btn_s;
  logic [NES_BITS-1:0] buttons_f;

  assign sync_w  = g_sync[SYNC_STAGES-1].q;
  assign latch_s = sync_w[NES_BITS+1];
  assign nclk_s  = sync_w[NES_BITS];
  assign btn_s   = sync_w[NES_BITS-1:0];

`ifdef NES_DEBOUNCE_EN
  for (genvar b = 0; b < NES_BITS; b++) begin : g_db
    nes_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (btn_s[b]),
      .dout (buttons_f[b])
    );
  end
`else
  assign buttons_f = btn_s;
`endif

  logic latch_d;
  logic nclk_d;
  logic latch_rise;
  logic latch_fall;
  logic nclk_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_d <= 1'b0;
      nclk_d  <= 1'b0;
    end else begin
      latch_d <= latch_s;
      nclk_d  <= nclk_s;
    end
  end

  assign latch_rise = latch_s & ~latch_d;
  assign latch_fall = ~latch_s & latch_d;
  assign nclk_rise  = nclk_s & ~nclk_d;

  nes_state_e          state;
  logic [NES_BITS-1:0] sr;
  logic [3:0]          bit_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic                tmo_sat;
  logic                tmo_last;

  assign tmo_sat  = (tmo_cnt == TW'(FRAME_TIMEOUT));
  assign tmo_last = (tmo_cnt == TW'(FRAME_TIMEOUT - 1));
  assign data     = sr[0];

  // latch rise outranks timeout and shifting in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '1;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      frame_done  <= 1'b0;
      link_active <= 1'b0;
      snapshot    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (latch_rise) begin
        state       <= LOAD;
        sr          <= ~buttons_f;
        bit_cnt     <= '0;
        tmo_cnt     <= '0;
        link_active <= 1'b1;
      end else if (tmo_last) begin
        state       <= IDLE;
        sr          <= '1;
        bit_cnt     <= '0;
        tmo_cnt     <= TW'(FRAME_TIMEOUT);
        link_active <= 1'b0;
      end else begin
        if (!tmo_sat) tmo_cnt <= tmo_cnt + TW'(1);
        unique case (state)
          IDLE: sr <= '1;
          LOAD: begin
            sr      <= ~buttons_f;
            bit_cnt <= '0;
            if (latch_fall) begin
              snapshot <= buttons_f;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (nclk_rise) begin
              sr      <= {1'b0, sr[NES_BITS-1:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end
          end
          DONE: begin
            if (nclk_rise) begin
              sr      <= {1'b0, sr[NES_BITS-1:1]};
              bit_cnt <= 4'd8;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder: directed-vector bench for nes_pad_responder.
// Drives host latch/nes_clk on negedges and samples outputs on negedges.
module tb_nes_pad_responder;

  localparam int FT = 20000;

  logic       clk;
  logic       reset;
  logic       latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       data;
  logic       frame_done;
  logic       link_active;
  logic [7:0] snapshot;

  int checks;
  int errors;
  int fd_cnt;
  int fd0;

  nes_pad_responder #(
    .SYNC_STAGES    (2),
    .FRAME_TIMEOUT  (FT),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .latch      (latch),
    .nes_clk    (nes_clk),
    .buttons    (buttons),
    .data       (data),
    .frame_done (frame_done),
    .link_active(link_active),
    .snapshot   (snapshot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    repeat (1200) @(negedge clk);
    latch = 1'b0;
    repeat (300) @(negedge clk);
  endtask

  task automatic nclk_pulse();
    nes_clk = 1'b1;
    repeat (300) @(negedge clk);
    nes_clk = 1'b0;
    repeat (300) @(negedge clk);
  endtask

  task automatic read_bits(input string tag, input logic [7:0] exp_bits,
                           input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), 32'(data), 32'(exp_bits[i]));
      nclk_pulse();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    fd_cnt  = 0;
    reset   = 1'b0;
    latch   = 1'b0;
    nes_clk = 1'b0;
    buttons = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_link", 32'(link_active), 32'd0);
    chk("rst_snap", 32'(snapshot), 32'h00);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      repeat (2000) @(negedge clk);
      chk("idle_data", 32'(data), 32'd1);
      chk("idle_link", 32'(link_active), 32'd0);
      chk("idle_snap", 32'(snapshot), 32'h00);
    end

    // full frame, A + start
    buttons = 8'h09;
    fd0 = fd_cnt;
    latch_pulse();
    chk("f1_snap", 32'(snapshot), 32'h09);
    chk("f1_link", 32'(link_active), 32'd1);
    read_bits("f1", 8'hF6, 7);
    chk("f1_fd_early", 32'(fd_cnt - fd0), 32'd0);
    chk("f1_bit7", 32'(data), 32'd1);
    nclk_pulse();
    chk("f1_fd", 32'(fd_cnt - fd0), 32'd1);
    chk("f1_after8", 32'(data), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nclk_pulse();
      chk("f1_extra", 32'(data), 32'd0);
    end
    chk("f1_fd_extra", 32'(fd_cnt - fd0), 32'd1);
    chk("f1_bitcnt", 32'(dut.bit_cnt), 32'd8);

    // abort after 3 shifts, then full frame with up pressed
    fd0 = fd_cnt;
    latch_pulse();
    read_bits("ab", 8'hF6, 3);
    buttons = 8'h10;
    repeat (50) @(negedge clk);
    chk("ab_hold", 32'(data), 32'd0);
    latch = 1'b1;
    repeat (10) @(negedge clk);
    chk("ab_load", 32'(data), 32'd1);
    repeat (1190) @(negedge clk);
    latch = 1'b0;
    repeat (300) @(negedge clk);
    chk("ab_nofd", 32'(fd_cnt - fd0), 32'd0);
    chk("f2_snap", 32'(snapshot), 32'h10);
    read_bits("f2", 8'hEF, 8);
    chk("f2_fd", 32'(fd_cnt - fd0), 32'd1);

    // latch and nes_clk rise together while in DONE
    buttons = 8'h02;
    fd0 = fd_cnt;
    latch   = 1'b1;
    nes_clk = 1'b1;
    repeat (300) @(negedge clk);
    nes_clk = 1'b0;
    repeat (900) @(negedge clk);
    latch = 1'b0;
    repeat (300) @(negedge clk);
    chk("sc_snap", 32'(snapshot), 32'h02);
    read_bits("sc", 8'hFD, 8);
    chk("sc_fd", 32'(fd_cnt - fd0), 32'd1);

    // timeout: counted from the negedge latch is driven high
    buttons = 8'h01;
    latch = 1'b1;
    repeat (1200) @(negedge clk);
    latch = 1'b0;
    repeat (300) @(negedge clk);
    chk("to_data_pre", 32'(data), 32'd0);
    repeat (FT + 2 - 1500) @(negedge clk);
    chk("to_link_pre", 32'(link_active), 32'd1);
    @(negedge clk);
    chk("to_link", 32'(link_active), 32'd0);
    chk("to_data", 32'(data), 32'd1);
    nclk_pulse();
    chk("to_ignore", 32'(data), 32'd1);

`ifdef NES_DEBOUNCE_EN
    buttons = 8'h00;
    repeat (50) @(negedge clk);
    buttons = 8'h01;
    repeat (10) @(negedge clk);
    buttons = 8'h00;
    repeat (50) @(negedge clk);
    latch_pulse();
    chk("db_glitch", 32'(snapshot), 32'h00);
    buttons = 8'h01;
    repeat (20) @(negedge clk);
    latch_pulse();
    chk("db_press", 32'(snapshot), 32'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
